// File: rtl/ewrapper_link_pkg.sv
// Shared constants, command-byte layout and FSM encoding for the link TX mux.
package ewrapper_link_pkg;

  localparam int PKT_BYTES = 16;

  // Bit positions inside command byte B0
  localparam int B0_ACCESS_BIT = 0;
  localparam int B0_WRITE_BIT  = 1;
  localparam int B0_DM_LSB     = 2;
  localparam int B0_CTRL_LSB   = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } tx_state_e;

  // Serialises one emesh transaction into wire order: byte k at [8k+7:8k],
  // multi-byte fields most-significant byte first.
  function automatic logic [8*PKT_BYTES-1:0] build_pkt(
    input logic        write,
    input logic [1:0]  datamode,
    input logic [3:0]  ctrlmode,
    input logic [31:0] dstaddr,
    input logic [31:0] data,
    input logic [31:0] srcaddr
  );
    logic [7:0] b0;
    b0 = '0;
    b0[B0_ACCESS_BIT]     = 1'b1;
    b0[B0_WRITE_BIT]      = write;
    b0[B0_DM_LSB +: 2]    = datamode;
    b0[B0_CTRL_LSB +: 4]  = ctrlmode;
    build_pkt = {24'h000000,
                 srcaddr[7:0], srcaddr[15:8], srcaddr[23:16], srcaddr[31:24],
                 data[7:0], data[15:8], data[23:16], data[31:24],
                 dstaddr[7:0], dstaddr[15:8], dstaddr[23:16], dstaddr[31:24],
                 b0};
  endfunction

endpackage

// File: rtl/ewrapper_link_rr_arb.sv
// Round-robin arbiter: one-hot grant to the first requester after last_i.
module ewrapper_link_rr_arb #(
  parameter int NCH = 2,
  localparam int LW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic [NCH-1:0] req_i,
  input  logic [LW-1:0]  last_i,
  output logic [NCH-1:0] gnt_o
);

  logic          found;
  logic [LW-1:0] idx;

  // Search starts one past the previous winner and wraps modulo NCH
  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= NCH; k++) begin
      idx = LW'((int'(last_i) + k) % NCH);
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ewrapper_link_tx_mux.sv
// Multiplexes NCH emesh sources onto the link, one 16-byte packet at a time.
//
// Source handshake: a channel offers a transaction by raising access; it is
// taken on the edge where access=1 and its holding slot is free (wr_wait=0),
// or on the edge the slot is granted away. wr_wait mirrors the slot state.
module ewrapper_link_tx_mux
  import ewrapper_link_pkg::*;
#(
  parameter int NCH      = 2,
  parameter int BYTES    = 8,
  parameter int IDLE_GAP = 0
) (
  input  logic               txo_lclk,
  input  logic               reset,
  input  logic [NCH-1:0]     emesh_access_outb,
  input  logic [NCH-1:0]     emesh_write_outb,
  input  logic [2*NCH-1:0]   emesh_datamode_outb,
  input  logic [4*NCH-1:0]   emesh_ctrlmode_outb,
  input  logic [32*NCH-1:0]  emesh_dstaddr_outb,
  input  logic [32*NCH-1:0]  emesh_srcaddr_outb,
  input  logic [32*NCH-1:0]  emesh_data_outb,
  output logic [NCH-1:0]     emesh_wr_wait_inb,
  input  logic               txo_wr_wait,
  input  logic               txo_rd_wait,
  output logic [9*BYTES-1:0] tx_in,
  output tx_state_e          dbg_state_o
);

  localparam int BEATS = PKT_BYTES / BYTES;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int LW    = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int PW    = 8 * PKT_BYTES;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
  localparam logic [2:0]    GAP_LAST  = (IDLE_GAP > 0) ? 3'(IDLE_GAP - 1) : 3'd0;

  tx_state_e          state_q, state_d;
  logic [BW-1:0]      beat_q, beat_d;
  logic [2:0]         gap_q, gap_d;
  logic [LW-1:0]      last_q, last_d;
  logic [PW-1:0]      pkt_q, pkt_d;
  logic [9*BYTES-1:0] tx_q, tx_d;

  logic [NCH-1:0]     hold_valid_q, hold_wr_q;
  logic [PW-1:0]      hold_pkt_q [NCH];

  logic [NCH-1:0]     eligible, gnt, clr;
  logic               take;
  logic [PW-1:0]      sel_pkt;
  logic [LW-1:0]      gnt_idx;

  function automatic logic [9*BYTES-1:0] beat_word(input logic [PW-1:0] p,
                                                   input logic [BW-1:0] j);
    beat_word = {{BYTES{1'b1}}, p[j*8*BYTES +: 8*BYTES]};
  endfunction

  // Link waits only gate channels at grant time; a started packet runs out
  always_comb begin
    eligible = '0;
    for (int i = 0; i < NCH; i++) begin
      eligible[i] = hold_valid_q[i] & (hold_wr_q[i] ? ~txo_wr_wait : ~txo_rd_wait);
    end
  end

  ewrapper_link_rr_arb #(.NCH(NCH)) u_arb (
    .req_i  (eligible),
    .last_i (last_q),
    .gnt_o  (gnt)
  );

  // One-hot grant to packet and channel index
  always_comb begin
    sel_pkt = '0;
    gnt_idx = '0;
    for (int i = 0; i < NCH; i++) begin
      if (gnt[i]) begin
        sel_pkt = sel_pkt | hold_pkt_q[i];
        gnt_idx = LW'(i);
      end
    end
  end

  // Next state: the final GAP cycle doubles as the idle decision point so the
  // wire carries exactly IDLE_GAP blank cycles between packets under load.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    gap_d   = gap_q;
    last_d  = last_q;
    pkt_d   = pkt_q;
    tx_d    = '0;
    take    = 1'b0;
    clr     = '0;
    case (state_q)
      ST_IDLE: take = 1'b1;
      ST_SEND: begin
        if (beat_q == LAST_BEAT) begin
          if (IDLE_GAP > 0) begin
            state_d = ST_GAP;
            gap_d   = 3'd0;
          end else begin
            take = 1'b1;
          end
        end else begin
          beat_d = beat_q + 1'b1;
          tx_d   = beat_word(pkt_q, beat_q + 1'b1);
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_LAST) take = 1'b1;
        else                   gap_d = gap_q + 3'd1;
      end
      default: state_d = ST_IDLE;
    endcase
    if (take) begin
      gap_d = 3'd0;
      if (|gnt) begin
        state_d = ST_SEND;
        beat_d  = '0;
        pkt_d   = sel_pkt;
        last_d  = gnt_idx;
        tx_d    = beat_word(sel_pkt, '0);
        clr     = gnt;
      end else begin
        state_d = ST_IDLE;
      end
    end
  end

  // Engine registers; reset abandons any packet in flight
  always_ff @(posedge txo_lclk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      beat_q  <= '0;
      gap_q   <= 3'd0;
      last_q  <= LW'(NCH - 1);
      pkt_q   <= '0;
      tx_q    <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      gap_q   <= gap_d;
      last_q  <= last_d;
      pkt_q   <= pkt_d;
      tx_q    <= tx_d;
    end
  end

  // Holding slots: a new capture wins over the grant-clear on the same edge
  always_ff @(posedge txo_lclk) begin
    if (reset) begin
      hold_valid_q <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (emesh_access_outb[i] && (!hold_valid_q[i] || clr[i])) begin
          hold_valid_q[i] <= 1'b1;
          hold_wr_q[i]    <= emesh_write_outb[i];
          hold_pkt_q[i]   <= build_pkt(emesh_write_outb[i],
                                       emesh_datamode_outb[2*i +: 2],
                                       emesh_ctrlmode_outb[4*i +: 4],
                                       emesh_dstaddr_outb[32*i +: 32],
                                       emesh_data_outb[32*i +: 32],
                                       emesh_srcaddr_outb[32*i +: 32]);
        end else if (clr[i]) begin
          hold_valid_q[i] <= 1'b0;
        end
      end
    end
  end

  assign emesh_wr_wait_inb = hold_valid_q;
  assign tx_in             = tx_q;
  assign dbg_state_o       = state_q;

endmodule
